// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter that lets two requesters share one combinational ALU.
// A granted request drives the ALU bus directly. The result and flags are
// captured into a single-entry response buffer that honours consumer
// backpressure.
module alu_share_arbiter #(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_a_valid,
  input  logic [CTRL_W-1:0] i_a_ctrl,
  input  logic [WIDTH-1:0]  i_a_op1,
  input  logic [WIDTH-1:0]  i_a_op2,
  output logic              o_a_ready,
  input  logic              i_b_valid,
  input  logic [CTRL_W-1:0] i_b_ctrl,
  input  logic [WIDTH-1:0]  i_b_op1,
  input  logic [WIDTH-1:0]  i_b_op2,
  output logic              o_b_ready,
  output logic [CTRL_W-1:0] o_alu_ctrl,
  output logic [WIDTH-1:0]  o_alu_1,
  output logic [WIDTH-1:0]  o_alu_2,
  input  logic [WIDTH-1:0]  i_alu_result,
  input  logic              i_alu_zero,
  input  logic              i_alu_neg,
  input  logic              i_alu_negU,
  output logic              o_rsp_valid,
  output logic              o_rsp_id,
  output logic [WIDTH-1:0]  o_rsp_data,
  output logic              o_rsp_zero,
  output logic              o_rsp_neg,
  output logic              o_rsp_negU,
  output logic              o_rsp_err,
  input  logic              i_rsp_ready
);

  // Defined opcodes are 0..7 (arith/logic/shifts) plus 13 (slt) and 14 (sltu).
  function automatic logic ctrl_defined(input logic [CTRL_W-1:0] ctrl);
    return (ctrl <= CTRL_W'(7)) || (ctrl == CTRL_W'(13)) || (ctrl == CTRL_W'(14));
  endfunction

  logic              grant_a;
  logic              grant_b;
  logic              slot_free;
  logic              accept;
  logic              accept_b;
  logic              ctrl_ok;

  logic              last_b_p1;
  logic              rsp_vld_p1;
  logic              rsp_id_p1;
  logic [WIDTH-1:0]  rsp_data_p1;
  logic              rsp_zero_p1;
  logic              rsp_neg_p1;
  logic              rsp_negu_p1;
  logic              rsp_err_p1;

  // Grant: a lone requester wins; on contention the one not served last wins.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (i_a_valid && (!i_b_valid || last_b_p1)) begin
      grant_a = 1'b1;
    end else if (i_b_valid) begin
      grant_b = 1'b1;
    end
  end

  assign slot_free = !rsp_vld_p1 || i_rsp_ready;
  assign o_a_ready = grant_a && slot_free;
  assign o_b_ready = grant_b && slot_free;
  assign accept_b  = i_b_valid && o_b_ready;
  assign accept    = (i_a_valid && o_a_ready) || accept_b;

  // ALU bus follows the granted requester and is forced to zero when idle.
  always_comb begin
    o_alu_ctrl = '0;
    o_alu_1    = '0;
    o_alu_2    = '0;
    if (grant_a) begin
      o_alu_ctrl = i_a_ctrl;
      o_alu_1    = i_a_op1;
      o_alu_2    = i_a_op2;
    end else if (grant_b) begin
      o_alu_ctrl = i_b_ctrl;
      o_alu_1    = i_b_op1;
      o_alu_2    = i_b_op2;
    end
  end

  assign ctrl_ok = ctrl_defined(o_alu_ctrl);

  // ---- response buffer stage (p1) ----
  // Capture on accept; release the slot when consumed without a new accept.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      last_b_p1   <= 1'b1;
      rsp_vld_p1  <= 1'b0;
      rsp_id_p1   <= 1'b0;
      rsp_data_p1 <= '0;
      rsp_zero_p1 <= 1'b0;
      rsp_neg_p1  <= 1'b0;
      rsp_negu_p1 <= 1'b0;
      rsp_err_p1  <= 1'b0;
    end else if (accept) begin
      last_b_p1   <= accept_b;
      rsp_vld_p1  <= 1'b1;
      rsp_id_p1   <= accept_b;
      rsp_data_p1 <= ctrl_ok ? i_alu_result : '0;
      rsp_zero_p1 <= ctrl_ok && i_alu_zero;
      rsp_neg_p1  <= ctrl_ok && i_alu_neg;
      rsp_negu_p1 <= ctrl_ok && i_alu_negU;
      rsp_err_p1  <= !ctrl_ok;
    end else if (i_rsp_ready) begin
      rsp_vld_p1  <= 1'b0;
    end
  end

  assign o_rsp_valid = rsp_vld_p1;
  assign o_rsp_id    = rsp_id_p1;
  assign o_rsp_data  = rsp_data_p1;
  assign o_rsp_zero  = rsp_zero_p1;
  assign o_rsp_neg   = rsp_neg_p1;
  assign o_rsp_negU  = rsp_negu_p1;
  assign o_rsp_err   = rsp_err_p1;

endmodule
